// File: rtl/interp_ctrl_block_pkg.sv
// Shared definitions for the polyphase interpolator control sequencer:
// FSM state encoding, tap/phase derivations and a parameter-legality check.
package interp_ctrl_block_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WORK = 1'b1
  } state_t;

  // MAC cycles spent on one polyphase branch.
  function automatic int unsigned taps_per_phase(input int unsigned filter_length,
                                                 input int unsigned interp_k);
    return filter_length / interp_k;
  endfunction

  // Counter/index width; a single value still needs one bit.
  function automatic int unsigned phase_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Filter must split evenly into branches and fit in the RAM address space.
  function automatic bit params_legal(input int unsigned filter_length,
                                      input int unsigned interp_k,
                                      input int unsigned addr_width);
    return (interp_k >= 1) && ((filter_length % interp_k) == 0) &&
           (filter_length <= (1 << addr_width));
  endfunction

endpackage

// File: rtl/interp_ctrl_block_delay.sv
// ctrl_delay_line: fixed-depth shift register with synchronous active-high reset.
// Ports: i_clk, i_rst (sync, active high), i_d (input), o_q (i_d delayed Depth cycles).
module ctrl_delay_line #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_pipe [Depth];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(Depth); i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < int'(Depth); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[Depth-1];

endmodule

// File: rtl/interp_ctrl_block.sv
// Control sequencer for a single-MAC polyphase interpolator. Each accepted
// input sample triggers one run of InterpolationK branches, each branch
// FilterLength/InterpolationK MAC cycles long. One further sample may be held
// pending during a run; any more are dropped and flagged with Overrun_o.
// Ports:
//   Clk_i, Rst_i   clock, synchronous active-high reset
//   DataNd_i       new input sample, written at DataAddrWr_o
//   DataAddrWr_o   sample RAM write address
//   DataAddr_o     sample RAM read address (base - k)
//   CoeffAddr_o    coefficient RAM read address (k*InterpolationK + p)
//   StartAcc_o     accumulator clear/load strobe, aligned to the MAC pipeline
//   DataValid_o    accumulator holds a finished output sample
//   Phase_o        branch index of the sample flagged by DataValid_o
//   Busy_o         run in progress
//   Overrun_o      one-cycle pulse when an input sample is dropped
module interp_ctrl_block
  import interp_ctrl_block_pkg::*;
#(
  parameter int unsigned FilterLength   = 16,
  parameter int unsigned InterpolationK = 2,
  parameter int unsigned AddrWidth      = 4
) (
  input  logic                                  Clk_i,
  input  logic                                  Rst_i,
  input  logic                                  DataNd_i,
  output logic [AddrWidth-1:0]                  DataAddrWr_o,
  output logic [AddrWidth-1:0]                  DataAddr_o,
  output logic [AddrWidth-1:0]                  CoeffAddr_o,
  output logic                                  StartAcc_o,
  output logic                                  DataValid_o,
  output logic [phase_width(InterpolationK)-1:0] Phase_o,
  output logic                                  Busy_o,
  output logic                                  Overrun_o
);

  localparam int unsigned TapsPerPhase = taps_per_phase(FilterLength, InterpolationK);
  localparam int unsigned PhaseWidth   = phase_width(InterpolationK);
  localparam int unsigned TapWidth     = phase_width(TapsPerPhase);

  if (!params_legal(FilterLength, InterpolationK, AddrWidth)) begin : g_bad_params
    $error("interp_ctrl_block: illegal FilterLength/InterpolationK/AddrWidth combination");
  end

  state_t                r_state;
  logic [TapWidth-1:0]   r_k;
  logic [PhaseWidth-1:0] r_p;
  logic [AddrWidth-1:0]  r_wr_addr;
  logic [AddrWidth-1:0]  r_base;
  logic [AddrWidth-1:0]  r_pend_base;
  logic                  r_pending;
  logic [AddrWidth-1:0]  r_data_addr;
  logic [AddrWidth-1:0]  r_coeff_addr;
  logic                  r_overrun;

  logic                  w_start_acc;
  logic                  w_rdy;
  logic                  w_last_tap;
  logic                  w_last_phase;
  logic [PhaseWidth-1:0] w_phase_tag;

  // Internal strobes decoded from the current tap/phase counters.
  assign w_last_tap   = (r_k == TapWidth'(TapsPerPhase - 1));
  assign w_last_phase = (r_p == PhaseWidth'(InterpolationK - 1));
  assign w_start_acc  = (r_state == ST_WORK) && (r_k == '0);
  assign w_rdy        = (r_state == ST_WORK) && w_last_tap;
  assign w_phase_tag  = w_rdy ? r_p : '0;

  // Sequencer: counters, base/pending bookkeeping and RAM read addresses.
  // Read addresses are updated incrementally alongside k so no multiplier is needed.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_p          <= '0;
      r_wr_addr    <= '0;
      r_base       <= '0;
      r_pend_base  <= '0;
      r_pending    <= 1'b0;
      r_data_addr  <= '0;
      r_coeff_addr <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (DataNd_i) r_wr_addr <= r_wr_addr + AddrWidth'(1);

      case (r_state)
        ST_IDLE: begin
          r_k <= '0;
          r_p <= '0;
          if (DataNd_i) begin
            r_state      <= ST_WORK;
            r_base       <= r_wr_addr;
            r_data_addr  <= r_wr_addr;
            r_coeff_addr <= '0;
          end
        end

        ST_WORK: begin
          if (w_last_tap && w_last_phase) begin
            // End of run: chain straight into the next sample if one is available.
            r_k          <= '0;
            r_p          <= '0;
            r_coeff_addr <= '0;
            r_pending    <= 1'b0;
            if (DataNd_i) begin
              r_base      <= r_wr_addr;
              r_data_addr <= r_wr_addr;
            end else if (r_pending) begin
              r_base      <= r_pend_base;
              r_data_addr <= r_pend_base;
            end else begin
              r_state     <= ST_IDLE;
              r_data_addr <= r_base;
            end
          end else begin
            if (DataNd_i) begin
              if (!r_pending) begin
                r_pending   <= 1'b1;
                r_pend_base <= r_wr_addr;
              end else begin
                r_overrun <= 1'b1;
              end
            end
            if (w_last_tap) begin
              // Next branch reuses the same base.
              r_k          <= '0;
              r_p          <= r_p + PhaseWidth'(1);
              r_coeff_addr <= AddrWidth'(r_p) + AddrWidth'(1);
              r_data_addr  <= r_base;
            end else begin
              r_k          <= r_k + TapWidth'(1);
              r_coeff_addr <= r_coeff_addr + AddrWidth'(InterpolationK);
              r_data_addr  <= r_data_addr - AddrWidth'(1);
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Align strobes and phase tag to the 2-stage MAC pipeline.
  ctrl_delay_line #(.Width(1), .Depth(2)) u_start_dly (
    .i_clk (Clk_i),
    .i_rst (Rst_i),
    .i_d   (w_start_acc),
    .o_q   (StartAcc_o)
  );

  ctrl_delay_line #(.Width(1), .Depth(3)) u_rdy_dly (
    .i_clk (Clk_i),
    .i_rst (Rst_i),
    .i_d   (w_rdy),
    .o_q   (DataValid_o)
  );

  ctrl_delay_line #(.Width(PhaseWidth), .Depth(3)) u_phase_dly (
    .i_clk (Clk_i),
    .i_rst (Rst_i),
    .i_d   (w_phase_tag),
    .o_q   (Phase_o)
  );

  assign DataAddrWr_o = r_wr_addr;
  assign DataAddr_o   = r_data_addr;
  assign CoeffAddr_o  = r_coeff_addr;
  assign Busy_o       = (r_state == ST_WORK);
  assign Overrun_o    = r_overrun;

endmodule

// File: tb/tb_interp_ctrl_block.sv
// Directed bench for interp_ctrl_block (FilterLength=16, InterpolationK=2, AddrWidth=4).
// Each scenario records one trace of all outputs per cycle, then compares the
// trace against hand-derived cycle numbers and addresses.
module tb_interp_ctrl_block;

  localparam int unsigned AW   = 4;
  localparam int unsigned NCYC = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_nd;
  logic [AW-1:0] wr_addr, rd_addr, coeff_addr;
  logic          start_acc, data_valid, busy, overrun;
  logic [0:0]    phase;

  int n_run  = 0;
  int n_fail = 0;

  logic [AW-1:0] t_wr [NCYC];
  logic [AW-1:0] t_da [NCYC];
  logic [AW-1:0] t_ca [NCYC];
  logic          t_st [NCYC];
  logic          t_dv [NCYC];
  logic          t_ph [NCYC];
  logic          t_bz [NCYC];
  logic          t_ov [NCYC];

  always #5 clk = ~clk;

  interp_ctrl_block #(
    .FilterLength   (16),
    .InterpolationK (2),
    .AddrWidth      (AW)
  ) dut (
    .Clk_i        (clk),
    .Rst_i        (rst),
    .DataNd_i     (data_nd),
    .DataAddrWr_o (wr_addr),
    .DataAddr_o   (rd_addr),
    .CoeffAddr_o  (coeff_addr),
    .StartAcc_o   (start_acc),
    .DataValid_o  (data_valid),
    .Phase_o      (phase),
    .Busy_o       (busy),
    .Overrun_o    (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    data_nd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle c = interval between negedges; outputs recorded, then inputs for cycle c driven.
  task automatic run(input logic [63:0] nd, input logic [63:0] rs, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      t_wr[c] = wr_addr;
      t_da[c] = rd_addr;
      t_ca[c] = coeff_addr;
      t_st[c] = start_acc;
      t_dv[c] = data_valid;
      t_ph[c] = phase;
      t_bz[c] = busy;
      t_ov[c] = overrun;
      data_nd = nd[c];
      rst     = rs[c];
    end
    data_nd = 1'b0;
    rst     = 1'b0;
  endtask

  function automatic int count_dv(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (t_dv[c] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_ov(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (t_ov[c] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    rst     = 1'b1;
    data_nd = 1'b0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_wr",    wr_addr,    0);
    check("rst_da",    rd_addr,    0);
    check("rst_ca",    coeff_addr, 0);
    check("rst_start", start_acc,  0);
    check("rst_valid", data_valid, 0);
    check("rst_phase", phase,      0);
    check("rst_busy",  busy,       0);
    check("rst_ovr",   overrun,    0);

    // S1: single sample at cycle 0, base 0
    do_reset();
    run(64'd1, 64'd0, 24);
    check("s1_wr0", t_wr[0], 0);
    check("s1_wr1", t_wr[1], 1);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("s1_ca@%0d", c), t_ca[c], 2 * (c - 1));
      check($sformatf("s1_da@%0d", c), t_da[c], (c == 1) ? 0 : 17 - c);
    end
    for (int c = 9; c <= 16; c++) begin
      check($sformatf("s1_ca@%0d", c), t_ca[c], 2 * (c - 9) + 1);
      check($sformatf("s1_da@%0d", c), t_da[c], (c == 9) ? 0 : 25 - c);
    end
    for (int c = 0; c < 24; c++) begin
      check($sformatf("s1_start@%0d", c), t_st[c], (c == 3 || c == 11));
      check($sformatf("s1_valid@%0d", c), t_dv[c], (c == 11 || c == 19));
      check($sformatf("s1_busy@%0d", c), t_bz[c], (c >= 1 && c <= 16));
    end
    check("s1_phase@11", t_ph[11], 0);
    check("s1_phase@19", t_ph[19], 1);

    // S2: back-to-back, second sample in the last cycle of run 1
    do_reset();
    run(64'd1 | (64'd1 << 16), 64'd0, 40);
    check("s2_busy@16", t_bz[16], 1);
    check("s2_busy@17", t_bz[17], 1);
    check("s2_busy@33", t_bz[33], 0);
    check("s2_da@17", t_da[17], 1);
    check("s2_da@18", t_da[18], 0);
    check("s2_da@24", t_da[24], 10);
    check("s2_ca@17", t_ca[17], 0);
    check("s2_wr@17", t_wr[17], 2);
    check("s2_start@19", t_st[19], 1);
    check("s2_start@27", t_st[27], 1);
    for (int c = 20; c < 40; c++)
      check($sformatf("s2_valid@%0d", c), t_dv[c], (c == 27 || c == 35));
    check("s2_phase@27", t_ph[27], 0);
    check("s2_phase@35", t_ph[35], 1);
    check("s2_nvalid", count_dv(0, 39), 4);

    // S3: second sample mid-run goes pending, no overrun
    do_reset();
    run(64'd1 | (64'd1 << 5), 64'd0, 40);
    check("s3_da@17", t_da[17], 1);
    check("s3_da@18", t_da[18], 0);
    check("s3_busy@17", t_bz[17], 1);
    check("s3_nvalid", count_dv(0, 39), 4);
    check("s3_valid@35", t_dv[35], 1);
    check("s3_novr", count_ov(0, 39), 0);

    // S4: third sample while pending is set -> overrun at cycle 8
    do_reset();
    run(64'd1 | (64'd1 << 5) | (64'd1 << 7), 64'd0, 48);
    check("s4_ovr@8", t_ov[8], 1);
    check("s4_novr", count_ov(0, 47), 1);
    check("s4_wr@8", t_wr[8], 3);
    check("s4_da@17", t_da[17], 1);
    check("s4_nvalid", count_dv(0, 47), 4);

    // S5: reset during cycle 6 of a run
    do_reset();
    run(64'd1, 64'd1 << 6, 32);
    check("s5_busy@5", t_bz[5], 1);
    for (int c = 7; c < 32; c++) begin
      check($sformatf("s5_busy@%0d", c), t_bz[c], 0);
      check($sformatf("s5_valid@%0d", c), t_dv[c], 0);
      check($sformatf("s5_start@%0d", c), t_st[c], 0);
      check($sformatf("s5_wr@%0d", c), t_wr[c], 0);
      check($sformatf("s5_da@%0d", c), t_da[c], 0);
      check($sformatf("s5_ca@%0d", c), t_ca[c], 0);
    end

    // S6: 15 back-to-back samples (13 dropped), then one more with write address 15 -> wrap
    do_reset();
    run(64'h7FFF | (64'd1 << 40), 64'd0, 64);
    check("s6_novr", count_ov(0, 39), 13);
    check("s6_ovr@3", t_ov[3], 1);
    check("s6_ovr@15", t_ov[15], 1);
    check("s6_da@17", t_da[17], 1);
    check("s6_busy@33", t_bz[33], 0);
    check("s6_wr@40", t_wr[40], 15);
    check("s6_wr@41", t_wr[41], 0);
    for (int c = 41; c <= 48; c++)
      check($sformatf("s6_da@%0d", c), t_da[c], 15 - (c - 41));
    check("s6_valid@51", t_dv[51], 1);
    check("s6_phase@59", t_ph[59], 1);
    check("s6_nvalid", count_dv(0, 63), 6);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
